hazard_scoreboard: RTL and testbench
====================================

Name: hazard_scoreboard

Overview:
Parametrised next-generation pipeline hazard controller for the 5-stage core (fetch, decode, execute, memory, writeback).
- Generates stall and invalidate controls for fetch, decode, execute and memory.
- Adds optional operand forwarding and load-use detection.
- Adds a register scoreboard for variable-latency units (mul/div) that issue from execute and complete out of order.
- Sits beside the pipeline and is driven from every stage plus busio.

Parameters:
- REG_ADDR_WIDTH, 5: register address width; scoreboard holds 2**REG_ADDR_WIDTH bits, bit 0 never set.
- MAX_LONG_OPS, 2: maximum outstanding long-latency ops (1..7).
- FORWARDING, 1: 1 enables bypass selects; 0 gives stall-on-any-RAW mode, with forward selects held at 0.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-high reset
- rs1_address_decode, rs2_address_decode, rd_address_decode  in  REG_ADDR_WIDTH  decode operand/dest addresses (0 = unused)
- long_op_decode  in  1  decode instruction is long-latency
- rd_address_execute  in  REG_ADDR_WIDTH  execute dest (0 = none)
- load_execute  in  1  execute instruction is a load
- long_issue  in  1  execute instruction is long-latency; rd_address_execute is its dest
- csr_write_execute, csr_write_memory, csr_write_writeback  in  1  CSR write in stage
- rd_address_memory  in  REG_ADDR_WIDTH  memory-stage dest (0 = none)
- branch_taken, mret_memory, load_store  in  1  memory-stage events
- mret_writeback, traped, wfi  in  1  writeback events
- long_done  in  1  long unit writes its result this cycle
- long_done_address  in  REG_ADDR_WIDTH  dest of completing op
- fetch_ready, mem_ready  in  1  busio ready
- stall_fetch, invalidate_fetch, stall_decode, invalidate_decode, stall_execute, invalidate_execute, stall_memory, invalidate_memory  out  1  pipeline controls
- forward_rs1, forward_rs2  out  2  00 regfile, 01 execute result, 10 memory result
- long_busy  out  1  scoreboard count nonzero
- scoreboard_error  out  1  sticky: completion for non-pending register

Behaviour:
- Reset (async): pending bitmask = 0, count = 0, scoreboard_error = 0. All invalidate_* = 1 while reset is high; all stall_* = 0; forwards = 00.

Stall chain (combinational):
- stall_fetch = !inv_fetch && (stall_decode || inv_decode)
- stall_decode = !inv_decode && (stall_execute || inv_execute)
- stall_execute = !inv_execute && (stall_memory || inv_memory || (load_store && !mem_ready) || mret_memory)
- stall_memory = !inv_memory && wfi

Invalidate terms:
- trap_inv = mret_writeback || traped
- branch_inv = branch_taken || trap_inv
- invalidate_fetch = reset || branch_inv || (!fetch_ready && !inv_decode)
- invalidate_execute = reset || branch_inv
- invalidate_memory = reset || trap_inv || (load_store && !mem_ready)
- invalidate_decode = reset || branch_inv || any CSR write in execute, memory or writeback || raw_hazard || sb_hazard || (long_op_decode && count == MAX_LONG_OPS)

raw_hazard (only for nonzero rs matching a nonzero rd):
- FORWARDING=0: any rs matches rd_address_execute or rd_address_memory.
- FORWARDING=1: rs matches rd_address_execute && (load_execute || long_issue).

Forward select (FORWARDING=1), per operand:
- 01 if rs matches rd_address_execute, the execute instruction is not a load or long op, and rs != 0.
- Else 10 if rs matches rd_address_memory and rs != 0.
- Else 00.
- Execute has priority over memory. Selects are valid only when invalidate_decode = 0.

sb_hazard: pending[rs1], pending[rs2] (RAW) or pending[rd_address_decode] (WAW) is set, for nonzero addresses.

Scoreboard (registered, updates on rising clk):
- issue = long_issue && rd_address_execute != 0 && !invalidate_execute && !stall_execute
- done = long_done && long_done_address != 0 && pending[long_done_address]
- done clears its bit and issue sets its bit. When both target the same register, clear applies first, so the bit ends set.
- count += issue - done; both in the same cycle leaves count unchanged.
- long_done to a non-pending register: no state change, scoreboard_error set until reset.
- issue while count == MAX_LONG_OPS cannot occur, because decode is blocked. If it occurs anyway, count saturates and scoreboard_error is set.
- Flushes (branch/trap) do not clear pending bits; in-flight long ops always complete.
- long_busy = (count != 0).

Test Plan:
- Reset pulse mid-run with 2 pending ops -> pending = 0, count = 0, long_busy = 0 immediately; invalidate_* = 1 while reset is high.
- FORWARDING=1, execute rd=5 ALU op, decode rs1=5, rs2=5 -> invalidate_decode = 0, forward_rs1 = forward_rs2 = 01. Same with load_execute=1 -> invalidate_decode = 1 for one cycle, then forward 10.
- FORWARDING=0, memory rd=7, decode rs2=7 -> invalidate_decode = 1, forwards = 00. rs2=0 with rd=0 -> no hazard.
- long_issue rd=9, then decode rs1=9 -> invalidate_decode held until long_done addr 9; next cycle no hazard, count returns 0.
- MAX_LONG_OPS=2: two issues (rd 3, 4), decode long op -> blocked. Same-cycle issue rd=3 and done addr 3 -> bit 3 stays set, count unchanged.
- long_done addr 12 with nothing pending -> scoreboard_error = 1 and stays 1 until reset. traped with pending bit set -> bit retained.

Source files
------------

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: stall/invalidate control, operand forwarding and long-latency
// register scoreboard for the 5-stage core.
module hazard_scoreboard #(
  parameter int REG_ADDR_WIDTH = 5,
  parameter int MAX_LONG_OPS = 2,
  parameter int FORWARDING = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [REG_ADDR_WIDTH-1:0] rs1_address_decode,
  input  logic [REG_ADDR_WIDTH-1:0] rs2_address_decode,
  input  logic [REG_ADDR_WIDTH-1:0] rd_address_decode,
  input  logic                      long_op_decode,
  input  logic [REG_ADDR_WIDTH-1:0] rd_address_execute,
  input  logic                      load_execute,
  input  logic                      long_issue,
  input  logic                      csr_write_execute,
  input  logic                      csr_write_memory,
  input  logic                      csr_write_writeback,
  input  logic [REG_ADDR_WIDTH-1:0] rd_address_memory,
  input  logic                      branch_taken,
  input  logic                      mret_memory,
  input  logic                      load_store,
  input  logic                      mret_writeback,
  input  logic                      traped,
  input  logic                      wfi,
  input  logic                      long_done,
  input  logic [REG_ADDR_WIDTH-1:0] long_done_address,
  input  logic                      fetch_ready,
  input  logic                      mem_ready,
  output logic                      stall_fetch,
  output logic                      invalidate_fetch,
  output logic                      stall_decode,
  output logic                      invalidate_decode,
  output logic                      stall_execute,
  output logic                      invalidate_execute,
  output logic                      stall_memory,
  output logic                      invalidate_memory,
  output logic [1:0]                forward_rs1,
  output logic [1:0]                forward_rs2,
  output logic                      long_busy,
  output logic                      scoreboard_error
);
  localparam int REGS = 1 << REG_ADDR_WIDTH;
  localparam logic [2:0] MAX_CNT = 3'(MAX_LONG_OPS);
  logic [REGS-1:0] pending;
  logic [2:0] count;
  logic trap_inv, branch_inv, mem_wait, csr_busy;
  logic rs1_ex, rs2_ex, rs1_mem, rs2_mem, ex_fwd_ok;
  logic raw_hazard, sb_hazard, ops_full, issue, done, stray;
  assign trap_inv   = mret_writeback || traped;
  assign branch_inv = branch_taken || trap_inv;
  assign mem_wait   = load_store && !mem_ready;
  assign csr_busy   = csr_write_execute || csr_write_memory || csr_write_writeback;
  assign rs1_ex  = rs1_address_decode != '0 && rs1_address_decode == rd_address_execute;
  assign rs2_ex  = rs2_address_decode != '0 && rs2_address_decode == rd_address_execute;
  assign rs1_mem = rs1_address_decode != '0 && rs1_address_decode == rd_address_memory;
  assign rs2_mem = rs2_address_decode != '0 && rs2_address_decode == rd_address_memory;
  // loads and long ops have no result in execute yet, so they cannot be bypassed
  assign ex_fwd_ok  = !(load_execute || long_issue);
  assign raw_hazard = (FORWARDING != 0) ? ((rs1_ex || rs2_ex) && !ex_fwd_ok)
                                        : (rs1_ex || rs2_ex || rs1_mem || rs2_mem);
  // pending[0] is never set, so register 0 needs no explicit exclusion here
  assign sb_hazard = pending[rs1_address_decode] || pending[rs2_address_decode] ||
                     pending[rd_address_decode];
  assign ops_full  = count == MAX_CNT;
  assign invalidate_execute = reset || branch_inv;
  assign invalidate_memory  = reset || trap_inv || mem_wait;
  assign invalidate_decode  = reset || branch_inv || csr_busy || raw_hazard || sb_hazard ||
                              (long_op_decode && ops_full);
  assign invalidate_fetch   = reset || branch_inv || (!fetch_ready && !invalidate_decode);
  assign stall_memory  = !invalidate_memory && wfi;
  assign stall_execute = !invalidate_execute &&
                         (stall_memory || invalidate_memory || mem_wait || mret_memory);
  assign stall_decode  = !invalidate_decode && (stall_execute || invalidate_execute);
  assign stall_fetch   = !invalidate_fetch && (stall_decode || invalidate_decode);
  assign forward_rs1 = (FORWARDING == 0 || reset) ? 2'b00 :
                       (rs1_ex && ex_fwd_ok) ? 2'b01 : rs1_mem ? 2'b10 : 2'b00;
  assign forward_rs2 = (FORWARDING == 0 || reset) ? 2'b00 :
                       (rs2_ex && ex_fwd_ok) ? 2'b01 : rs2_mem ? 2'b10 : 2'b00;
  assign issue = long_issue && rd_address_execute != '0 && !invalidate_execute && !stall_execute;
  assign done  = long_done && long_done_address != '0 && pending[long_done_address];
  assign stray = long_done && !pending[long_done_address];
  assign long_busy = count != 3'd0;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending <= '0;
      count <= 3'd0;
      scoreboard_error <= 1'b0;
    end else begin
      if (done) pending[long_done_address] <= 1'b0;
      if (issue) pending[rd_address_execute] <= 1'b1;
      count <= (issue && !done && !ops_full) ? count + 3'd1 :
               (done && !issue) ? count - 3'd1 : count;
      if (stray || (issue && !done && ops_full)) scoreboard_error <= 1'b1;
    end
  end
endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: randomized scoreboard bench for hazard_scoreboard, checking
// a forwarding and a non-forwarding instance against a rule-level reference model.
module tb_hazard_scoreboard;
  localparam int MAXOPS = 2;
  typedef struct packed {
    logic reset;
    logic [4:0] rs1, rs2, rd_dec;
    logic long_op_dec;
    logic [4:0] rd_ex;
    logic load_ex, long_issue, csr_ex, csr_mem, csr_wb;
    logic [4:0] rd_mem;
    logic branch_taken, mret_mem, load_store, mret_wb, traped, wfi, long_done;
    logic [4:0] done_addr;
    logic fetch_ready, mem_ready;
  } stim_t;
  typedef struct {
    logic [13:0] e1;
    logic [13:0] e0;
    int cyc;
  } exp_t;
  logic clk = 1'b0;
  stim_t st;
  exp_t q[$];
  int checks = 0, fails = 0, cyc = 0;
  bit pend[32], npend[32];
  int cnt = 0, ncnt = 0;
  bit err = 0, nerr = 0;
  logic sf1, if1, sd1, id1, se1, ie1, sm1, im1, busy1, err1;
  logic sf0, if0, sd0, id0, se0, ie0, sm0, im0, busy0, err0;
  logic [1:0] f11, f21, f10, f20;
  wire [13:0] act1 = {sf1, if1, sd1, id1, se1, ie1, sm1, im1, f11, f21, busy1, err1};
  wire [13:0] act0 = {sf0, if0, sd0, id0, se0, ie0, sm0, im0, f10, f20, busy0, err0};
  always #5 clk = ~clk;
  hazard_scoreboard #(.REG_ADDR_WIDTH(5), .MAX_LONG_OPS(MAXOPS), .FORWARDING(1)) u1 (
    .clk(clk), .reset(st.reset), .rs1_address_decode(st.rs1), .rs2_address_decode(st.rs2),
    .rd_address_decode(st.rd_dec), .long_op_decode(st.long_op_dec), .rd_address_execute(st.rd_ex),
    .load_execute(st.load_ex), .long_issue(st.long_issue), .csr_write_execute(st.csr_ex),
    .csr_write_memory(st.csr_mem), .csr_write_writeback(st.csr_wb), .rd_address_memory(st.rd_mem),
    .branch_taken(st.branch_taken), .mret_memory(st.mret_mem), .load_store(st.load_store),
    .mret_writeback(st.mret_wb), .traped(st.traped), .wfi(st.wfi), .long_done(st.long_done),
    .long_done_address(st.done_addr), .fetch_ready(st.fetch_ready), .mem_ready(st.mem_ready),
    .stall_fetch(sf1), .invalidate_fetch(if1), .stall_decode(sd1), .invalidate_decode(id1),
    .stall_execute(se1), .invalidate_execute(ie1), .stall_memory(sm1), .invalidate_memory(im1),
    .forward_rs1(f11), .forward_rs2(f21), .long_busy(busy1), .scoreboard_error(err1));
  hazard_scoreboard #(.REG_ADDR_WIDTH(5), .MAX_LONG_OPS(MAXOPS), .FORWARDING(0)) u0 (
    .clk(clk), .reset(st.reset), .rs1_address_decode(st.rs1), .rs2_address_decode(st.rs2),
    .rd_address_decode(st.rd_dec), .long_op_decode(st.long_op_dec), .rd_address_execute(st.rd_ex),
    .load_execute(st.load_ex), .long_issue(st.long_issue), .csr_write_execute(st.csr_ex),
    .csr_write_memory(st.csr_mem), .csr_write_writeback(st.csr_wb), .rd_address_memory(st.rd_mem),
    .branch_taken(st.branch_taken), .mret_memory(st.mret_mem), .load_store(st.load_store),
    .mret_writeback(st.mret_wb), .traped(st.traped), .wfi(st.wfi), .long_done(st.long_done),
    .long_done_address(st.done_addr), .fetch_ready(st.fetch_ready), .mem_ready(st.mem_ready),
    .stall_fetch(sf0), .invalidate_fetch(if0), .stall_decode(sd0), .invalidate_decode(id0),
    .stall_execute(se0), .invalidate_execute(ie0), .stall_memory(sm0), .invalidate_memory(im0),
    .forward_rs1(f10), .forward_rs2(f20), .long_busy(busy0), .scoreboard_error(err0));

  function automatic int fwd_sel(input stim_t s, input int r);
    if (r == 0) return 0;
    if (r == int'(s.rd_ex) && !(s.load_ex || s.long_issue)) return 1;
    if (r == int'(s.rd_mem)) return 2;
    return 0;
  endfunction

  function automatic logic [13:0] model(input stim_t s, input bit fwd);
    bit trap, br, mw, ie, im, sm, se, raw, id, ifc, sd, sf;
    int f1, f2;
    int r[2];
    trap = s.mret_wb || s.traped;
    br = s.branch_taken || trap;
    mw = s.load_store && !s.mem_ready;
    ie = s.reset || br;
    im = s.reset || trap || mw;
    sm = !im && s.wfi;
    se = !ie && (sm || im || mw || s.mret_mem);
    r[0] = int'(s.rs1);
    r[1] = int'(s.rs2);
    raw = 0;
    for (int k = 0; k < 2; k++)
      if (r[k] != 0) begin
        if (fwd) raw |= r[k] == int'(s.rd_ex) && (s.load_ex || s.long_issue);
        else raw |= r[k] == int'(s.rd_ex) || r[k] == int'(s.rd_mem);
      end
    id = s.reset || br || s.csr_ex || s.csr_mem || s.csr_wb || raw ||
         pend[s.rs1] || pend[s.rs2] || pend[s.rd_dec] || (s.long_op_dec && cnt == MAXOPS);
    ifc = s.reset || br || (!s.fetch_ready && !id);
    sd = !id && (se || ie);
    sf = !ifc && (sd || id);
    f1 = (fwd && !s.reset) ? fwd_sel(s, r[0]) : 0;
    f2 = (fwd && !s.reset) ? fwd_sel(s, r[1]) : 0;
    return {sf, ifc, sd, id, se, ie, sm, im, 2'(f1), 2'(f2), cnt != 0, err};
  endfunction

  task automatic step(input stim_t s);
    exp_t e;
    bit issue, done;
    @(posedge clk);
    pend = npend;
    cnt = ncnt;
    err = nerr;
    #1;
    st = s;
    cyc++;
    if (s.reset) begin
      pend = '{default: 0};
      cnt = 0;
      err = 0;
    end
    e.e1 = model(s, 1);
    e.e0 = model(s, 0);
    e.cyc = cyc;
    q.push_back(e);
    npend = pend;
    ncnt = cnt;
    nerr = err;
    if (!s.reset) begin
      issue = s.long_issue && s.rd_ex != 0 && e.e1[8] == 1'b0 && e.e1[9] == 1'b0;
      done = s.long_done && s.done_addr != 0 && pend[s.done_addr];
      if (s.long_done && !pend[s.done_addr]) nerr = 1;
      if (done) npend[s.done_addr] = 0;
      if (issue) npend[s.rd_ex] = 1;
      if (issue && !done) begin
        if (cnt == MAXOPS) nerr = 1;
        else ncnt = cnt + 1;
      end else if (done && !issue) ncnt = cnt - 1;
    end
  endtask

  function automatic stim_t idle();
    stim_t s = '0;
    s.fetch_ready = 1;
    s.mem_ready = 1;
    return s;
  endfunction

  function automatic logic [4:0] addr();
    return ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
  endfunction

  function automatic stim_t rnd(input int i);
    stim_t s = idle();
    int live[$];
    for (int k = 1; k < 32; k++) if (pend[k]) live.push_back(k);
    s.reset = (i % 200 == 199);
    s.rs1 = addr();
    s.rs2 = addr();
    s.rd_dec = addr();
    s.long_op_dec = $urandom_range(0, 4) == 0;
    s.rd_ex = addr();
    s.load_ex = $urandom_range(0, 3) == 0;
    s.long_issue = $urandom_range(0, 6) == 0;
    s.csr_ex = $urandom_range(0, 19) == 0;
    s.csr_mem = $urandom_range(0, 19) == 0;
    s.csr_wb = $urandom_range(0, 19) == 0;
    s.rd_mem = addr();
    s.branch_taken = $urandom_range(0, 9) == 0;
    s.mret_mem = $urandom_range(0, 29) == 0;
    s.load_store = $urandom_range(0, 2) == 0;
    s.mem_ready = $urandom_range(0, 9) < 7;
    s.mret_wb = $urandom_range(0, 29) == 0;
    s.traped = $urandom_range(0, 19) == 0;
    s.wfi = $urandom_range(0, 19) == 0;
    s.fetch_ready = $urandom_range(0, 9) != 0;
    if (live.size() != 0 && $urandom_range(0, 2) == 0) begin
      s.long_done = 1;
      s.done_addr = 5'(live[$urandom_range(0, live.size() - 1)]);
    end else if ($urandom_range(0, 99) == 0) begin
      s.long_done = 1;
      s.done_addr = 5'($urandom_range(1, 31));
    end
    return s;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (q.size() != 0) begin
      e = q.pop_front();
      checks++;
      if (act1 !== e.e1) begin
        fails++;
        $display("FAIL fwd1_outputs cycle %0d: got %b expected %b", e.cyc, act1, e.e1);
      end
      checks++;
      if (act0 !== e.e0) begin
        fails++;
        $display("FAIL fwd0_outputs cycle %0d: got %b expected %b", e.cyc, act0, e.e0);
      end
    end
  end

  initial begin
    stim_t s;
    st = idle();
    st.reset = 1;
    s = idle(); s.reset = 1; step(s); step(s);
    s = idle(); step(s);
    s = idle(); s.rd_ex = 5; s.rs1 = 5; s.rs2 = 5; step(s);
    s.load_ex = 1; step(s);
    s = idle(); s.rd_mem = 5; s.rs1 = 5; s.rs2 = 5; step(s);
    s = idle(); s.rd_mem = 7; s.rs2 = 7; step(s);
    s = idle(); step(s);
    s = idle(); s.long_issue = 1; s.rd_ex = 9; step(s);
    s = idle(); s.rs1 = 9; step(s); step(s); step(s);
    s.long_done = 1; s.done_addr = 9; step(s);
    s = idle(); s.rs1 = 9; step(s);
    s = idle(); s.long_issue = 1; s.rd_ex = 3; step(s);
    s.rd_ex = 4; step(s);
    s = idle(); s.long_op_dec = 1; step(s);
    s = idle(); s.long_issue = 1; s.rd_ex = 3; s.long_done = 1; s.done_addr = 3; step(s);
    s = idle(); s.rs1 = 3; step(s);
    s = idle(); s.reset = 1; step(s);
    s = idle(); s.rs1 = 3; s.rs2 = 4; step(s);
    s = idle(); s.long_issue = 1; s.rd_ex = 6; step(s);
    s = idle(); s.long_done = 1; s.done_addr = 12; step(s);
    s = idle(); s.traped = 1; step(s);
    s = idle(); s.rs1 = 6; step(s);
    s = idle(); s.long_done = 1; s.done_addr = 6; step(s);
    s = idle(); step(s);
    s = idle(); s.reset = 1; step(s);
    for (int i = 0; i < 1500; i++) step(rnd(i));
    @(posedge clk);
    @(negedge clk);
    #1;
    checks++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL drain: got %0d pending expectations, required 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
